// File: rtl/fc_layer_seq_pkg.sv
// Shared state encoding, parameter-memory address map and output-stage arithmetic
// for the sequential fully connected layer.
package fc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COMPUTE = 2'd1;
  localparam state_t ST_OUTPUT  = 2'd2;

  // Weights occupy [0, in*out); biases follow immediately after.
  function automatic int weight_base();
    return 0;
  endfunction

  function automatic int bias_base(input int in_f, input int out_f);
    return in_f * out_f;
  endfunction

  function automatic int prm_depth(input int in_f, input int out_f);
    return out_f * (in_f + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Floor shift by frac, then clamp to a signed width-bit range.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] val,
                                                   input int frac, input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = val >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Streaming input/output handshakes plus the parameter write port of fc_layer_seq.
interface fc_layer_seq_if
  import fc_pkg::*;
#(
  parameter int IN_FEATURES  = 16,
  parameter int OUT_FEATURES = 8,
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_W       = $clog2(prm_depth(IN_FEATURES, OUT_FEATURES))
);
  logic                              in_valid;
  logic                              in_ready;
  logic [IN_FEATURES*DATA_SIZE-1:0]  in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [OUT_FEATURES*DATA_SIZE-1:0] out_data;
  logic                              prm_we;
  logic [ADDR_W-1:0]                 prm_addr;
  logic [DATA_SIZE-1:0]              prm_data;
  logic                              busy;

  modport slave (
    input  in_valid, in_data, out_ready, prm_we, prm_addr, prm_data,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, out_ready, prm_we, prm_addr, prm_data,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fc_layer_seq_mac.sv
// Single signed MAC with bias-initialised accumulation and the shift/saturate/ReLU
// output stage; res_o reflects the sum being written this cycle.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ACC_SIZE  = 24,
  parameter int FRAC_BITS = 0,
  parameter int RELU      = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic                        first_i,
  input  logic signed [DATA_SIZE-1:0] x_i,
  input  logic signed [DATA_SIZE-1:0] w_i,
  input  logic signed [DATA_SIZE-1:0] b_i,
  output logic signed [DATA_SIZE-1:0] res_o
);
  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]    prod_ext;
  logic signed [ACC_SIZE-1:0]    bias_ext;
  logic signed [ACC_SIZE-1:0]    sum_d;
  logic signed [ACC_SIZE-1:0]    acc_q;
  logic signed [63:0]            sat;

  assign prod     = x_i * w_i;
  assign prod_ext = ACC_SIZE'(prod);
  assign bias_ext = ACC_SIZE'(b_i) <<< FRAC_BITS;
  assign sum_d    = first_i ? (bias_ext + prod_ext) : (acc_q + prod_ext);

  always_ff @(posedge clk) begin
    if (!rst_n)    acc_q <= '0;
    else if (en_i) acc_q <= sum_d;
  end

  assign sat   = shift_sat({{(64-ACC_SIZE){sum_d[ACC_SIZE-1]}}, sum_d}, FRAC_BITS, DATA_SIZE);
  assign res_o = ((RELU != 0) && (sat < 0)) ? '0 : sat[DATA_SIZE-1:0];
endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fully connected layer: FSM, index counters, input/output registers and
// parameter memory around one time-multiplexed MAC.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int IN_FEATURES  = 16,
  parameter int OUT_FEATURES = 8,
  parameter int DATA_SIZE    = 8,
  parameter int ACC_SIZE     = 24,
  parameter int FRAC_BITS    = 0,
  parameter int RELU         = 0,
  parameter int ADDR_W       = $clog2(prm_depth(IN_FEATURES, OUT_FEATURES))
) (
  input  logic clk,
  input  logic rst_n,
  fc_layer_seq_if.slave bus
);
  localparam int NW    = IN_FEATURES * OUT_FEATURES;
  localparam int DEPTH = prm_depth(IN_FEATURES, OUT_FEATURES);
  localparam int BBASE = bias_base(IN_FEATURES, OUT_FEATURES);
  localparam int IW    = idx_width(IN_FEATURES);
  localparam int JW    = idx_width(OUT_FEATURES);
  localparam int WAW   = idx_width(NW);
  localparam logic [IW-1:0] I_LAST = IW'(IN_FEATURES - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OUT_FEATURES - 1);

  state_t state_q, state_d;
  logic [IW-1:0]  i_q, ip_q;
  logic [JW-1:0]  j_q, jp_q;
  logic [WAW-1:0] waddr_q;
  logic issue_done_q, vld_q, first_q, last_q;

  logic signed [DATA_SIZE-1:0] w_mem [NW];
  logic signed [DATA_SIZE-1:0] b_mem [OUT_FEATURES];
  logic signed [DATA_SIZE-1:0] w_rd_q, b_rd_q;
  logic signed [DATA_SIZE-1:0] in_q  [IN_FEATURES];
  logic signed [DATA_SIZE-1:0] out_q [OUT_FEATURES];
  logic signed [DATA_SIZE-1:0] mac_res;
  logic [ADDR_W-1:0]           b_off;

  logic accept, issue, row_done, all_done, prm_ok, prm_is_w;

  assign accept   = (state_q == ST_IDLE) && bus.in_valid;
  assign issue    = (state_q == ST_COMPUTE) && !issue_done_q;
  assign row_done = vld_q && last_q;
  assign all_done = row_done && (jp_q == J_LAST);
  assign prm_ok   = bus.prm_we && (state_q == ST_IDLE) &&
                    ({1'b0, bus.prm_addr} < (ADDR_W+1)'(DEPTH));
  assign prm_is_w = {1'b0, bus.prm_addr} < (ADDR_W+1)'(BBASE + weight_base());
  assign b_off    = bus.prm_addr - ADDR_W'(BBASE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept)        state_d = ST_COMPUTE;
      ST_COMPUTE: if (all_done)      state_d = ST_OUTPUT;
      ST_OUTPUT:  if (bus.out_ready) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Registered-read parameter memory; reads run one cycle ahead of the MAC stage.
  always_ff @(posedge clk) begin
    if (prm_ok) begin
      if (prm_is_w) w_mem[bus.prm_addr[WAW-1:0]] <= bus.prm_data;
      else          b_mem[b_off[JW-1:0]]         <= bus.prm_data;
    end
    w_rd_q <= w_mem[waddr_q];
    b_rd_q <= b_mem[j_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      waddr_q      <= '0;
      issue_done_q <= 1'b0;
      vld_q        <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      ip_q         <= '0;
      jp_q         <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= issue;
      first_q <= (i_q == '0);
      last_q  <= (i_q == I_LAST);
      ip_q    <= i_q;
      jp_q    <= j_q;
      if (accept) begin
        i_q          <= '0;
        j_q          <= '0;
        waddr_q      <= '0;
        issue_done_q <= 1'b0;
      end else if (issue) begin
        if (i_q != I_LAST) begin
          i_q     <= i_q + 1'b1;
          waddr_q <= waddr_q + 1'b1;
        end else if (j_q != J_LAST) begin
          i_q     <= '0;
          j_q     <= j_q + 1'b1;
          waddr_q <= waddr_q + 1'b1;
        end else begin
          issue_done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < IN_FEATURES; k++) in_q[k] <= bus.in_data[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_FEATURES; k++) out_q[k] <= '0;
    end else if (row_done) begin
      out_q[jp_q] <= mac_res;
    end
  end

  fc_mac_unit #(
    .DATA_SIZE (DATA_SIZE),
    .ACC_SIZE  (ACC_SIZE),
    .FRAC_BITS (FRAC_BITS),
    .RELU      (RELU)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (vld_q),
    .first_i (first_q),
    .x_i     (in_q[ip_q]),
    .w_i     (w_rd_q),
    .b_i     (b_rd_q),
    .res_o   (mac_res)
  );

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < OUT_FEATURES; k++) bus.out_data[k*DATA_SIZE +: DATA_SIZE] = out_q[k];
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_OUTPUT);
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench: 4x2 layer (plain and ReLU copies fed identically) and a 1x1 layer
// with two fraction bits.
module tb_fc_layer_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  fc_layer_seq_if #(.IN_FEATURES(4), .OUT_FEATURES(2), .DATA_SIZE(8)) bus_a ();
  fc_layer_seq_if #(.IN_FEATURES(4), .OUT_FEATURES(2), .DATA_SIZE(8)) bus_b ();
  fc_layer_seq_if #(.IN_FEATURES(1), .OUT_FEATURES(1), .DATA_SIZE(8)) bus_c ();

  fc_layer_seq #(.IN_FEATURES(4), .OUT_FEATURES(2), .DATA_SIZE(8), .ACC_SIZE(24),
                 .FRAC_BITS(0), .RELU(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  fc_layer_seq #(.IN_FEATURES(4), .OUT_FEATURES(2), .DATA_SIZE(8), .ACC_SIZE(24),
                 .FRAC_BITS(0), .RELU(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  fc_layer_seq #(.IN_FEATURES(1), .OUT_FEATURES(1), .DATA_SIZE(8), .ACC_SIZE(24),
                 .FRAC_BITS(2), .RELU(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // The ReLU copy sees exactly the stimulus of the plain copy.
  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.out_ready = bus_a.out_ready;
  assign bus_b.prm_we    = bus_a.prm_we;
  assign bus_b.prm_addr  = bus_a.prm_addr;
  assign bus_b.prm_data  = bus_a.prm_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] ea(input int j);
    logic [7:0] v;
    v = bus_a.out_data[8*j +: 8];
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic signed [31:0] eb(input int j);
    logic [7:0] v;
    v = bus_b.out_data[8*j +: 8];
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic signed [31:0] ec();
    logic [7:0] v;
    v = bus_c.out_data;
    return {{24{v[7]}}, v};
  endfunction

  task automatic prm_a(input int addr, input int val);
    bus_a.prm_we   = 1'b1;
    bus_a.prm_addr = addr[3:0];
    bus_a.prm_data = val[7:0];
    tick();
    bus_a.prm_we   = 1'b0;
  endtask

  task automatic prm_c(input int addr, input int val);
    bus_c.prm_we   = 1'b1;
    bus_c.prm_addr = addr[0];
    bus_c.prm_data = val[7:0];
    tick();
    bus_c.prm_we   = 1'b0;
  endtask

  task automatic run_a(input logic [31:0] vec, output int cyc);
    bus_a.in_data  = vec;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    cyc = 0;
    while (!bus_a.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_c(input logic [7:0] x, output int cyc);
    bus_c.in_data  = x;
    bus_c.in_valid = 1'b1;
    tick();
    bus_c.in_valid = 1'b0;
    cyc = 0;
    while (!bus_c.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic hs_a();
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
  endtask

  task automatic hs_c();
    bus_c.out_ready = 1'b1;
    tick();
    bus_c.out_ready = 1'b0;
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_a.prm_we = 1'b0; bus_a.prm_addr = '0; bus_a.prm_data = '0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;
    bus_c.prm_we = 1'b0; bus_c.prm_addr = '0; bus_c.prm_data = '0;

    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", bus_a.in_ready, 1);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_out_data", bus_a.out_data, 0);
    check("rst_c_in_ready", bus_c.in_ready, 1);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) prm_a(k, k + 1);
    for (int k = 4; k < 8; k++) prm_a(k, -1);
    prm_a(8, 5);
    prm_a(9, 0);
    prm_c(0, 3);
    prm_c(1, 0);

    // Basic layer and its ReLU twin
    run_a(32'h01010101, lat);
    check("basic_latency", lat, 9);
    check("basic_out0", ea(0), 15);
    check("basic_out1", ea(1), -4);
    check("relu_out0", eb(0), 15);
    check("relu_out1", eb(1), 0);
    check("output_busy", bus_a.busy, 1);
    check("output_in_ready", bus_a.in_ready, 0);
    hs_a();
    check("hs_out_valid", bus_a.out_valid, 0);
    check("hs_in_ready", bus_a.in_ready, 1);

    // Backpressure with parameter writes attempted while holding the result
    run_a(32'h01010101, lat);
    bus_a.prm_we = 1'b1; bus_a.prm_addr = 4'd0; bus_a.prm_data = 8'd100;
    repeat (10) tick();
    bus_a.prm_we = 1'b0;
    check("bp_out_valid", bus_a.out_valid, 1);
    check("bp_out_data", bus_a.out_data, 16'hFC0F);
    check("bp_in_ready", bus_a.in_ready, 0);
    hs_a();
    run_a(32'h01010101, lat);
    check("bp_rerun_out0", ea(0), 15);
    check("bp_rerun_out1", ea(1), -4);
    hs_a();

    // Reset in the middle of a computation
    bus_a.in_data = 32'h01010101;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_out_valid", bus_a.out_valid, 0);
    check("abort_in_ready", bus_a.in_ready, 1);
    check("abort_busy", bus_a.busy, 0);
    run_a(32'h01010101, lat);
    check("abort_rerun_latency", lat, 9);
    check("abort_rerun_out0", ea(0), 15);
    check("abort_rerun_out1", ea(1), -4);
    hs_a();

    // Back-to-back vectors, in_valid and out_ready held high
    bus_a.out_ready = 1'b1;
    bus_a.in_data = 32'h01010101;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_data = 32'h01000002;
    lat = 0;
    while (!bus_a.out_valid && lat < 200) begin tick(); lat++; end
    check("b2b_latency1", lat, 9);
    check("b2b_v1_out0", ea(0), 15);
    check("b2b_v1_out1", ea(1), -4);
    tick();
    check("b2b_hs_out_valid", bus_a.out_valid, 0);
    check("b2b_hs_in_ready", bus_a.in_ready, 1);
    tick();
    bus_a.in_valid = 1'b0;
    check("b2b_second_accepted", bus_a.busy, 1);
    lat = 0;
    while (!bus_a.out_valid && lat < 200) begin tick(); lat++; end
    check("b2b_latency2", lat, 9);
    check("b2b_v2_out0", ea(0), 11);
    check("b2b_v2_out1", ea(1), -3);
    tick();
    bus_a.out_ready = 1'b0;
    check("b2b_done_valid", bus_a.out_valid, 0);

    // Saturation at both rails
    for (int k = 0; k < 8; k++) prm_a(k, 127);
    run_a(32'h7f7f7f7f, lat);
    check("sat_pos_out0", ea(0), 127);
    check("sat_pos_out1", ea(1), 127);
    check("sat_pos_relu1", eb(1), 127);
    hs_a();
    for (int k = 0; k < 8; k++) prm_a(k, -128);
    run_a(32'h7f7f7f7f, lat);
    check("sat_neg_out0", ea(0), -128);
    check("sat_neg_out1", ea(1), -128);
    check("sat_neg_relu0", eb(0), 0);
    hs_a();

    // Single-product layer with two fraction bits
    run_c(8'h03, lat);
    check("frac_latency", lat, 2);
    check("frac_pos", ec(), 2);
    hs_c();
    run_c(8'hfd, lat);
    check("frac_neg", ec(), -3);
    hs_c();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
Sequential, parametrised fully connected layer: out[j] = act(sat((bias[j] << FRAC_BITS + sum_i in[i]*W[j][i]) >>> FRAC_BITS)).
Time-multiplexes one signed MAC across all IN_FEATURES*OUT_FEATURES products, so a wide layer does not need a combinational multiplier array.
Weights and biases sit in internal parameter memory, loaded through a write port.
Sits between convolution/flatten stages and the classifier, with valid/ready streaming on both sides.

Parameters:
IN_FEATURES, 16, input vector length (>=1)
OUT_FEATURES, 8, output vector length (>=1)
DATA_SIZE, 8, signed width of inputs, weights, biases and outputs
ACC_SIZE, 24, signed accumulator width (>= 2*DATA_SIZE + clog2(IN_FEATURES) + 1 recommended)
FRAC_BITS, 0, fixed-point fraction bits; accumulator is shifted right by this amount before saturation
RELU, 0, 1 = clamp negative results to 0
ADDR_W, clog2(OUT_FEATURES*(IN_FEATURES+1)), parameter-port address width

Ports:
clk  in  1  single clock; everything is rising-edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  IN_FEATURES*DATA_SIZE  element i at [i*DATA_SIZE +: DATA_SIZE], signed
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts the result
out_data  out  OUT_FEATURES*DATA_SIZE  element j at [j*DATA_SIZE +: DATA_SIZE], signed
prm_we  in  1  parameter write strobe
prm_addr  in  ADDR_W  weight W[j][i] at j*IN_FEATURES+i; bias[j] at OUT_FEATURES*IN_FEATURES+j
prm_data  in  DATA_SIZE  signed parameter value
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; in_ready=1, out_valid=0, out_data=0, busy=0, accumulator=0, indices i=j=0.
- Reset does not clear parameter memory. Contents persist across reset and are undefined until written.
- States: IDLE, COMPUTE, OUTPUT.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, latch in_data into the input register and go to COMPUTE with i=0, j=0.
  - prm_we writes are honoured only in IDLE, one write per cycle. Writes in other states, and addresses >= OUT_FEATURES*(IN_FEATURES+1), are ignored.
  - An acceptance and a prm write in the same cycle are legal. The write completes first, and the new value is used by this computation.
- COMPUTE: one MAC per cycle.
  - At i=0: acc = (bias[j] sign-extended << FRAC_BITS) + in[0]*W[j][0].
  - Else: acc += in[i]*W[j][i].
  - Products are full 2*DATA_SIZE signed, sign-extended to ACC_SIZE. Accumulator overflow wraps and is not detected.
- End of output j (i=IN_FEATURES-1): the final sum goes through the following steps and is written to out_data slot j in the same cycle; then i=0 and j increments.
  - Arithmetic shift right by FRAC_BITS (floor).
  - Saturate to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - If RELU, apply max(0, .).
- After slot OUT_FEATURES-1 is written, go to OUTPUT.
- Latency: out_valid rises exactly OUT_FEATURES*IN_FEATURES+1 cycles after the acceptance edge.
- out_data slots not yet computed hold their previous values and are not exposed while out_valid=0.
- OUTPUT:
  - out_valid=1; out_data is stable until the handshake.
  - On out_valid&&out_ready, go to IDLE; out_valid=0 the next cycle.
  - in_ready is 0 during COMPUTE and OUTPUT, so there is no overlap: one vector in flight.
- IN_FEATURES=1: each output takes one cycle. OUT_FEATURES=1: a single pass.
- Reset mid-COMPUTE or mid-OUTPUT: abort; the partial result is discarded and out_valid=0 next cycle.

Decomposition:
- Package fc_pkg:
  - state encoding (IDLE/COMPUTE/OUTPUT);
  - a saturate/shift function parametrised by widths;
  - an address-map helper (weight/bias base offsets).
- Sub-module fc_mac_unit: signed multiply, accumulate with bias-init select, shift/saturate/ReLU output stage.
- The top level holds the FSM, index counters, input register, parameter memory and output register.

Test Plan:
1. Basic: IN=4, OUT=2, DATA=8, FRAC=0, RELU=0. W0={1,2,3,4}, b0=5; W1={-1,-1,-1,-1}, b1=0; input {1,1,1,1} -> out={15,-4}; out_valid exactly 9 cycles after acceptance.
2. ReLU: case 1 with RELU=1 -> out={15,0}.
3. Saturation and fraction:
   - All W=127, inputs=127 -> each out=127.
   - W=-128, inputs=127 -> out=-128.
   - FRAC_BITS=2, single product 3*3 with b=0 -> out=2; -9 -> out=-3.
4. Backpressure: out_ready held low 10 cycles -> out_valid stays 1, out_data stable, in_ready=0, prm writes ignored (memory readback via a rerun shows old values).
5. Reset mid-COMPUTE at cycle 4 -> next cycle out_valid=0, in_ready=1, busy=0; weights still present (rerun of case 1 gives {15,-4}).
6. Back-to-back vectors with out_ready=1 and in_valid held high -> second vector accepted the cycle after the OUTPUT handshake; results correct for both.
